mux_32to1: RTL and testbench
============================

# mux_32to1

Registered 32-way word multiplexer: selects one of N packed W-bit input words by a binary select and presents it on a registered output one clock later. Used in the datapath wherever one word out of a 32-entry source must be picked. Examples are register-file read ports and result/operand selection. Purely combinational select logic ends in a single output register with asynchronous active-low reset.

## Interface
- N, default 32, number of input words (≥2).
- WIDTH, default 32, bits per word.
- SEL_W, default 5, select width; must equal ceil(log2(N)).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- d  input  N*WIDTH  packed input words: word i occupies d[i*WIDTH +: WIDTH]. Word 0 is at the LSBs and word N-1 at the MSBs, so bits [31:0] hold word 0 and bits [1023:992] hold word 31 at defaults.
- sel  input  SEL_W  unsigned index of the word to route.
- y  output  WIDTH  registered selected word.

## Operation
- Combinational next value: next = d[sel*WIDTH +: WIDTH] when sel < N; next = 0 when sel ≥ N (possible only for non-power-of-two N).
- On each rising clk with rst_n high: y <= next.
- Selection is a pure index; no priority, no enable, no hold other than the register itself.
- sel and d are sampled only at the clock edge. Changes between edges have no effect on y until the next edge.
- No X-propagation masking: an X on a selected bit appears on y; X on unselected words must not affect y.
- All WIDTH bits are routed unchanged. There is no sign or zero extension and no bit reordering.

## Timing
- Reset: rst_n low forces y = 0 immediately, with no clock required. y stays 0 while rst_n is low regardless of d/sel.
- Reset release: the first rising clk with rst_n high loads next; no extra idle cycles.
- Latency: exactly 1 clock from (d, sel) sampled at edge k to y valid after edge k.
- Throughput: one new selection per cycle. Back-to-back different sel values produce back-to-back outputs.
- Reset asserted mid-stream: y clears asynchronously. The pending sample is discarded and not replayed after release.
- Combinational path d/sel → register D input must close timing in one cycle. The path is an N:1 mux tree of depth SEL_W.

## Test plan
- Reset: drive rst_n=0 with d words all 0xFFFFFFFF and sel=7 -> y=0 with no clock edge. Release rst_n, then one edge -> y=0xFFFFFFFF.
- Full sweep: load word i = i for i=0..31 and step sel 0..31, one per cycle -> y equals sel one cycle after each sel is applied. For example, sel=0 -> 0, sel=17 -> 17, sel=31 -> 31.
- Packing/endianness: word 0 = 0x0000_0001, word 31 = 0x8000_0000, others 0. sel=0 -> 0x00000001 and sel=31 -> 0x80000000, confirming LSB-first packing and no bit reversal.
- Isolation: hold sel=5 with word 5 = 0xDEADBEEF and toggle every other word randomly for 20 cycles -> y stays 0xDEADBEEF throughout.
- Mid-stream reset: sweep sel with word i = i and pulse rst_n low for less than one cycle between edges -> y drops to 0 at the pulse. At the next edge after release, y equals the word for the sel value then present.
- Non-power-of-two build (N=24, SEL_W=5): sel=23 -> word 23, and sel=24..31 -> y=0.

Source files
------------

// File: rtl/mux_32to1_if.sv
// Bundle for the registered word multiplexer: packed source words, select
// index, and the registered selected word.
interface mux_32to1_if #(
  parameter int N     = 32,
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
);
  logic [N*WIDTH-1:0] d;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   y;

  modport master (output d, output sel, input y);
  modport slave  (input d, input sel, output y);
endinterface

// File: rtl/mux_32to1.sv
// Registered N:1 word multiplexer: a binary mux tree of depth SEL_W feeding one
// output register. Indices at or beyond N read zero padding.
module mux_32to1 #(
  parameter int N     = 32,
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  mux_32to1_if.slave bus
);
  localparam int LEAVES = 1 << SEL_W;

  logic [LEAVES*WIDTH-1:0] leaf_s;
  logic [WIDTH-1:0]        y_d;
  logic [WIDTH-1:0]        y_q;

  // Pad unused leaves with zero so out-of-range selects resolve to 0 in the tree.
  if (LEAVES > N) begin : g_pad
    assign leaf_s = {{((LEAVES-N)*WIDTH){1'b0}}, bus.d};
  end else begin : g_nopad
    assign leaf_s = bus.d[LEAVES*WIDTH-1:0];
  end

  // Level l halves the candidates using sel[l]; a known select bit never lets
  // an unselected word leak into the result.
  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int CNT = LEAVES >> (l + 1);
    logic [2*CNT*WIDTH-1:0] in_s;
    logic [CNT*WIDTH-1:0]   out_s;

    if (l == 0) begin : g_first
      assign in_s = leaf_s;
    end else begin : g_next
      assign in_s = g_lvl[l-1].out_s;
    end

    for (genvar k = 0; k < CNT; k++) begin : g_node
      assign out_s[k*WIDTH +: WIDTH] = bus.sel[l] ? in_s[(2*k+1)*WIDTH +: WIDTH]
                                                  : in_s[(2*k)*WIDTH +: WIDTH];
    end
  end

  assign y_d = g_lvl[SEL_W-1].out_s;

  // Output register; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= {WIDTH{1'b0}};
    end else begin
      y_q <= y_d;
    end
  end

  assign bus.y = y_q;
endmodule

// File: tb/tb_mux_32to1.sv
// Directed bench for mux_32to1 (N=32 and N=24 builds) with a queue scoreboard.
module tb_mux_32to1;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux_32to1_if #(.N(32), .WIDTH(32), .SEL_W(5)) bus32 ();
  mux_32to1_if #(.N(24), .WIDTH(32), .SEL_W(5)) bus24 ();

  mux_32to1 #(.N(32), .WIDTH(32), .SEL_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  mux_32to1 #(.N(24), .WIDTH(32), .SEL_W(5)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24));

  logic [31:0] q32[$];
  logic [31:0] q24[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge and are captured on the next rising edge.
  task automatic put32(input logic [1023:0] dv, input int s, input logic [31:0] e);
    @(negedge clk);
    bus32.d   = dv;
    bus32.sel = s[4:0];
    q32.push_back(e);
  endtask

  task automatic put24(input logic [767:0] dv, input int s, input logic [31:0] e);
    @(negedge clk);
    bus24.d   = dv;
    bus24.sel = s[4:0];
    q24.push_back(e);
  endtask

  // Monitor: anything queued before a rising edge is due on y just after it.
  always begin
    int c32;
    int c24;
    logic [31:0] e;
    @(posedge clk);
    c32 = q32.size();
    c24 = q24.size();
    #1;
    if (c32 > 0) begin
      e = q32.pop_front();
      check("y32", bus32.y, e);
    end
    if (c24 > 0) begin
      e = q24.pop_front();
      check("y24", bus24.y, e);
    end
  end

  initial begin
    logic [1023:0] dv;
    logic [767:0]  dv24;

    bus32.d   = {1024{1'b1}};
    bus32.sel = 5'd7;
    bus24.d   = {768{1'b0}};
    bus24.sel = 5'd0;

    // Asynchronous reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #2;
    check("rst_async32", bus32.y, 32'h0000_0000);
    check("rst_async24", bus24.y, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rst_hold32", bus32.y, 32'h0000_0000);

    // Release; the very next edge loads the selected all-ones word.
    @(negedge clk);
    rst_n = 1'b1;
    q32.push_back(32'hFFFF_FFFF);

    // Full sweep: word i = i.
    for (int i = 0; i < 32; i++) dv[i*32 +: 32] = i[31:0];
    for (int s = 0; s < 32; s++) put32(dv, s, s[31:0]);

    // Packing and bit order.
    dv = {1024{1'b0}};
    dv[31:0]     = 32'h0000_0001;
    dv[1023:992] = 32'h8000_0000;
    put32(dv, 0, 32'h0000_0001);
    put32(dv, 31, 32'h8000_0000);
    put32(dv, 1, 32'h0000_0000);
    put32(dv, 30, 32'h0000_0000);

    // Isolation: only word 5 is stable.
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 32; i++) dv[i*32 +: 32] = $urandom;
      dv[5*32 +: 32] = 32'hDEAD_BEEF;
      put32(dv, 5, 32'hDEAD_BEEF);
    end

    // Mid-stream reset pulse between edges.
    for (int i = 0; i < 32; i++) dv[i*32 +: 32] = i[31:0];
    put32(dv, 3, 32'd3);
    put32(dv, 4, 32'd4);
    put32(dv, 5, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_clear", bus32.y, 32'h0000_0000);
    #1 rst_n = 1'b1;
    put32(dv, 6, 32'd6);

    // Non-power-of-two build: indices 24..31 read zero.
    for (int i = 0; i < 24; i++) dv24[i*32 +: 32] = 32'h100 + i[31:0];
    put24(dv24, 0, 32'h0000_0100);
    put24(dv24, 23, 32'h0000_0117);
    for (int s = 24; s < 32; s++) put24(dv24, s, 32'h0000_0000);
    put24(dv24, 12, 32'h0000_010C);

    repeat (3) @(negedge clk);
    check("drain", 32'(q32.size() + q24.size()), 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
